sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_if.sv | 28 ++
 rtl/sync_fifo.sv | 99 +++++++++
 2 files changed

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo: the producer/consumer side drives
// through the master modport, and the FIFO implements the slave modport.
interface sync_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build has registered rdata.
module sync_fifo #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave bus
);
  localparam int             DEPTH      = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT   = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic full, empty, wr_en, rd_en;

  // Every flag comes straight off the count register, so no flag lags count.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign wr_en = bus.winc && !full;
  assign rd_en = bus.rinc && !empty;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.winc & full);
    underflow_d = underflow_q | (bus.rinc & empty);

    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wptr_q[ASIZE-1:0]] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata = mem[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[rptr_q[ASIZE-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;
`endif

  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.almost_full  = (count_q >= AFULL_CNT);
  assign bus.almost_empty = (count_q <= AEMPTY_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
